// File: rtl/nrs_gold_seq_if.sv
// Request/stream bundle between the c_init generator, the Gold sequence
// generator and the NRS QPSK mapper.
interface nrs_gold_seq_if #(
    parameter int CINIT_W = 28
);
    logic [CINIT_W-1:0] cinit;
    logic               cinit_valid;
    logic               c_bit;
    logic               c_valid;
    logic               c_last;
    logic               busy;

    modport master (output cinit, cinit_valid, input  c_bit, c_valid, c_last, busy);
    modport slave  (input  cinit, cinit_valid, output c_bit, c_valid, c_last, busy);
endinterface

// File: rtl/nrs_gold_seq_gen.sv
// Length-31 Gold sequence generator: loads x1/x2 per request, advances them
// NC+START steps, then streams NUM_BITS consecutive c(n) bits.
module nrs_gold_seq_gen #(
    parameter int CINIT_W  = 28,
    parameter int NC       = 1600,
    parameter int START    = 218,
    parameter int NUM_BITS = 4,
    parameter int CNT_W    = 12
) (
    input  logic           clk,
    input  logic           rst,
    nrs_gold_seq_if.slave  bus
);
    localparam int              ADV      = NC + START;
    localparam logic [CNT_W-1:0] ADV_LAST = CNT_W'((ADV > 0) ? ADV - 1 : 0);
    localparam logic [CNT_W-1:0] NB_LAST  = CNT_W'(NUM_BITS - 1);
    localparam logic [30:0]      X1_INIT  = 31'd1;

    typedef enum logic [1:0] {IDLE, WARM, OUT} state_t;

    state_t             state, state_nxt;
    logic [30:0]        x1, x2;
    logic [CNT_W-1:0]   cnt;
    logic [CINIT_W-1:0] cinit_q;
    logic               load, step, cnt_clr, cnt_inc;
    logic               bit_nxt, vld_nxt, last_nxt;
    logic               c_bit_q, c_valid_q, c_last_q, busy_q;

    assign cinit_q     = bus.cinit;
    assign bus.c_bit   = c_bit_q;
    assign bus.c_valid = c_valid_q;
    assign bus.c_last  = c_last_q;
    assign bus.busy    = busy_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        bit_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        last_nxt  = 1'b0;
        case (state)
            IDLE: if (bus.cinit_valid) begin
                load      = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = (ADV == 0) ? OUT : WARM;
            end
            WARM: begin
                step = 1'b1;
                // Final warm-up advance happens on the edge that enters OUT
                if (cnt == ADV_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = OUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            OUT: begin
                step    = 1'b1;
                bit_nxt = x1[0] ^ x2[0];
                vld_nxt = 1'b1;
                if (cnt == NB_LAST) begin
                    last_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1        <= '0;
            x2        <= '0;
            cnt       <= '0;
            c_bit_q   <= 1'b0;
            c_valid_q <= 1'b0;
            c_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (load) begin
                x1 <= X1_INIT;
                x2 <= 31'(cinit_q);
            end else if (step) begin
                x1 <= {x1[3] ^ x1[0], x1[30:1]};
                x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            c_bit_q   <= bit_nxt;
            c_valid_q <= vld_nxt;
            c_last_q  <= last_nxt;
            // Low during the c_last cycle so the next request is accepted back to back
            busy_q    <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Scoreboard bench: default-parameter DUT (index 0) and NC=0/START=0 DUT (index 1).
module tb_nrs_gold_seq_gen;
    localparam int NC_D = 1600, START_D = 218;
    localparam int ADV_D = NC_D + START_D;

    typedef struct {
        logic b;
        logic last;
        int   edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[2][$];
    string nm[2] = '{"dflt", "small"};

    nrs_gold_seq_if #(.CINIT_W(28)) bus_d ();
    nrs_gold_seq_if #(.CINIT_W(28)) bus_s ();

    nrs_gold_seq_gen #(.CINIT_W(28), .NC(NC_D), .START(START_D), .NUM_BITS(4), .CNT_W(12))
        dut_d (.clk(clk), .rst(rst), .bus(bus_d));
    nrs_gold_seq_gen #(.CINIT_W(28), .NC(0), .START(0), .NUM_BITS(4), .CNT_W(12))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic mvld[2], mbit[2], mlast[2];
    assign mvld[0] = bus_d.c_valid;  assign mbit[0] = bus_d.c_bit;  assign mlast[0] = bus_d.c_last;
    assign mvld[1] = bus_s.c_valid;  assign mbit[1] = bus_s.c_bit;  assign mlast[1] = bus_s.c_last;

    // Monitor: every c_valid cycle must match the head of that DUT's queue
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (mvld[i]) begin
                checks++;
                if (q[i].size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected c_valid at edge %0d", nm[i], edge_cnt);
                end else begin
                    e = q[i].pop_front();
                    if (mbit[i] !== e.b || mlast[i] !== e.last || edge_cnt != e.edge_no) begin
                        errors++;
                        $display("FAIL %s stream: got bit=%0b last=%0b edge=%0d, need bit=%0b last=%0b edge=%0d",
                                 nm[i], mbit[i], mlast[i], edge_cnt, e.b, e.last, e.edge_no);
                    end
                end
            end else if (q[i].size() != 0 && q[i][0].edge_no <= edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL %s missing c_valid: edge %0d, need at edge %0d", nm[i], edge_cnt, q[i][0].edge_no);
                void'(q[i].pop_front());
            end
        end
    end

    // Reference: x(n+31) recurrences over whole-sequence arrays
    bit mx1[0:1899];
    bit mx2[0:1899];
    function automatic logic [3:0] model(input logic [27:0] ci, input int nc, input int n0);
        logic [3:0] r;
        int top;
        top = nc + n0 + 4;
        for (int i = 0; i < 31; i++) begin
            mx1[i] = (i == 0);
            mx2[i] = (i < 28) ? ci[i] : 1'b0;
        end
        for (int n = 0; n + 31 < top; n++) begin
            mx1[n+31] = mx1[n+3] ^ mx1[n];
            mx2[n+31] = mx2[n+3] ^ mx2[n+2] ^ mx2[n+1] ^ mx2[n];
        end
        for (int j = 0; j < 4; j++) r[j] = mx1[nc+n0+j] ^ mx2[nc+n0+j];
        return r;
    endfunction

    function automatic logic [27:0] cinit_of(input int id, input int ns, input int l);
        return 28'(1024 * (7 * (ns + 1) + l + 1) * (2 * id + 1) + 2 * id + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic [27:0] ci, input logic v);
        if (s == 0) begin bus_d.cinit = ci; bus_d.cinit_valid = v; end
        else        begin bus_s.cinit = ci; bus_s.cinit_valid = v; end
    endtask

    // Called at a negedge; the next posedge is the sampling edge k.
    // Returns at the negedge after edge k with k in kout.
    task automatic req(input int s, input logic [27:0] ci, input logic [3:0] bits,
                       input int nexp, output int kout);
        exp_t e;
        int adv;
        adv = (s == 0) ? ADV_D : 0;
        drive(s, ci, 1'b1);
        kout = edge_cnt + 1;
        for (int j = 0; j < nexp; j++) begin
            e.b = bits[j];
            e.last = (j == 3);
            e.edge_no = kout + adv + 1 + j;
            q[s].push_back(e);
        end
        @(negedge clk);
        drive(s, 28'd0, 1'b0);
    endtask

    task automatic wait_edge(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (q[0].size() != 0 || q[1].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d/%0d entries left", q[0].size(), q[1].size());
            q[0].delete();
            q[1].delete();
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " c_valid"}, {31'd0, bus_d.c_valid}, 32'd0);
        chk({name, " c_last"},  {31'd0, bus_d.c_last},  32'd0);
        chk({name, " c_bit"},   {31'd0, bus_d.c_bit},   32'd0);
        chk({name, " busy"},    {31'd0, bus_d.busy},    32'd0);
    endtask

    initial begin
        int k, k2;
        logic [27:0] ci;
        drive(0, 28'd0, 1'b0);
        drive(1, 28'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset small busy", {31'd0, bus_s.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Small-parameter exact windows, back to back on c_last
        req(1, 28'h0, 4'b0001, 4, k);
        wait_edge(k + 4);
        req(1, 28'h1, 4'b0000, 4, k);
        wait_edge(k + 4);
        req(1, 28'hF, 4'b1110, 4, k);
        drain(20);

        // Small-parameter sweep, back to back
        for (int id = 0; id < 504; id++)
            for (int ns = 0; ns < 20; ns += 19)
                for (int l = 5; l <= 6; l++) begin
                    ci = cinit_of(id, ns, l);
                    req(1, ci, model(ci, 0, 0), 4, k);
                    wait_edge(k + 4);
                end
        drain(20);

        // Default latency and values
        req(0, 28'd13313, model(28'd13313, NC_D, START_D), 4, k);
        chk("busy after accept", {31'd0, bus_d.busy}, 32'd1);
        drain(2000);
        chk_idle("idle after 13313");
        req(0, 28'd151582703, model(28'd151582703, NC_D, START_D), 4, k);
        drain(2000);

        // Request while busy is dropped
        req(0, 28'h1234, model(28'h1234, NC_D, START_D), 4, k);
        wait_edge(k + 99);
        drive(0, 28'h5678, 1'b1);
        @(negedge clk);
        drive(0, 28'd0, 1'b0);
        drain(2000);
        repeat (150) @(negedge clk);
        chk_idle("after busy drop");

        // Back to back: new request in the c_last cycle
        req(0, 28'h0ABCDEF, model(28'h0ABCDEF, NC_D, START_D), 4, k);
        wait_edge(k + ADV_D + 4);
        chk("c_last cycle", {31'd0, bus_d.c_last}, 32'd1);
        chk("busy in c_last cycle", {31'd0, bus_d.busy}, 32'd0);
        req(0, 28'd999, model(28'd999, NC_D, START_D), 4, k2);
        chk("b2b sample edge", k2, k + ADV_D + 5);
        drain(4000);

        // Reset mid-WARM, with a coincident request that must be ignored
        req(0, 28'h00ABCDE, 4'b0000, 0, k);
        wait_edge(k + 499);
        rst = 1'b1;
        drive(0, 28'h1111, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 28'd0, 1'b0);
        chk_idle("rst mid-warm");
        repeat (1900) @(negedge clk);
        chk_idle("after rst mid-warm");

        // Reset mid-OUT after the first bit
        ci = 28'd77777;
        req(0, ci, model(ci, NC_D, START_D), 1, k);
        wait_edge(k + ADV_D + 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst mid-out");
        repeat (40) @(negedge clk);
        chk_idle("after rst mid-out");
        drain(10);

        // Default-parameter sweep subset
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 3; b++) begin
                ci = cinit_of((a == 3) ? 503 : a * 167, (b == 2) ? 19 : b * 7, 5 + (a + b) % 2);
                req(0, ci, model(ci, NC_D, START_D), 4, k);
                wait_edge(k + ADV_D + 4);
            end
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
